// File: rtl/mem_mover_pkg.sv
// Shared state encoding and default sizing for the data-memory block mover.
// No logic; imported by the mover top and its index counter.
package mem_mover_pkg;

   localparam int DEF_AW  = 5;
   localparam int DEF_N   = 32;
   localparam int MAX_LEN = 2 ** DEF_AW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } mm_state_t;

endpackage

// File: rtl/mem_mover_counter.sv
// Word index for the block mover: cleared and armed with the run length on load, steps on inc.
// Single-cycle update; tc is combinational and flags the last word of the run.
module mem_mover_counter
   import mem_mover_pkg::*;
#(
   parameter int AW = DEF_AW
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          inc,
   input  logic [AW:0]   len,
   output logic [AW-1:0] ofs,
   output logic          tc
);

   logic [AW:0] idx_q;
   logic [AW:0] len_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         len_q <= '0;
      end else if (load) begin
         idx_q <= '0;
         len_q <= len;
      end else if (inc) begin
         idx_q <= idx_q + (AW+1)'(1);
      end
   end

   // idx_q never exceeds len_q-1, so idx_q+1 cannot overflow AW+1 bits.
   assign tc  = ((idx_q + (AW+1)'(1)) == len_q);
   assign ofs = idx_q[AW-1:0];

endmodule

// File: rtl/mem_block_mover.sv
// Block copy/fill engine owning the data-memory port while busy; copy costs 2 cycles/word, fill 1 cycle/word.
// No backpressure: Start is only honoured in IDLE; fill path built with MEM_MOVER_FILL_EN.
module mem_block_mover
   import mem_mover_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int AW = DEF_AW
)
(
   input  logic          Clock,
   input  logic          R,
   input  logic          Start,
   input  logic [AW-1:0] Src,
   input  logic [AW-1:0] Dst,
   input  logic [AW:0]   Len,
`ifdef MEM_MOVER_FILL_EN
   input  logic          Fill,
   input  logic [N-1:0]  FillData,
`endif
   input  logic [N-1:0]  MemReadData,
   output logic [AW-1:0] MemAddy,
   output logic          MemWriteEn,
   output logic [N-1:0]  MemWriteData,
   output logic          Busy,
   output logic          Done
);

   mm_state_t     state_q, state_d;
   logic [AW-1:0] src_q, dst_q;
   logic [N-1:0]  buf_q;
   logic [N-1:0]  wr_data;
   logic [AW-1:0] ofs;
   logic          tc;
   logic          cnt_load, cnt_inc, buf_cap;

`ifdef MEM_MOVER_FILL_EN
   logic          fill_q;
   logic [N-1:0]  filldata_q;
   assign wr_data = fill_q ? filldata_q : buf_q;
`else
   assign wr_data = buf_q;
`endif

   mem_mover_counter #(.AW(AW)) u_cnt (
      .clk  (Clock),
      .rst  (R),
      .load (cnt_load),
      .inc  (cnt_inc),
      .len  (Len),
      .ofs  (ofs),
      .tc   (tc)
   );

   always_ff @(posedge Clock) begin
      if (R) begin
         state_q    <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         buf_q      <= '0;
`ifdef MEM_MOVER_FILL_EN
         fill_q     <= 1'b0;
         filldata_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (cnt_load) begin
            src_q      <= Src;
            dst_q      <= Dst;
`ifdef MEM_MOVER_FILL_EN
            fill_q     <= Fill;
            filldata_q <= FillData;
`endif
         end
         if (buf_cap) begin
            buf_q <= MemReadData;
         end
      end
   end

   // Outputs decode straight from state so a reset lands every output at zero on the same edge.
   always_comb begin
      state_d      = state_q;
      MemAddy      = '0;
      MemWriteEn   = 1'b0;
      MemWriteData = '0;
      Busy         = 1'b0;
      Done         = 1'b0;
      cnt_load     = 1'b0;
      cnt_inc      = 1'b0;
      buf_cap      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               cnt_load = 1'b1;
               if (Len == '0) begin
                  state_d = DONE;
`ifdef MEM_MOVER_FILL_EN
               end else if (Fill) begin
                  state_d = WRITE;
`endif
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            MemAddy = src_q + ofs;
            Busy    = 1'b1;
            buf_cap = 1'b1;
            state_d = WRITE;
         end
         WRITE: begin
            MemAddy      = dst_q + ofs;
            MemWriteEn   = 1'b1;
            MemWriteData = wr_data;
            Busy         = 1'b1;
            cnt_inc      = 1'b1;
            if (tc) begin
               state_d = DONE;
`ifdef MEM_MOVER_FILL_EN
            end else if (fill_q) begin
               state_d = WRITE;
`endif
            end else begin
               state_d = READ;
            end
         end
         DONE: begin
            Done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover against a behavioural 32-word memory with combinational read.
module tb_mem_block_mover;

   logic        Clock = 1'b0;
   logic        R = 1'b1;
   logic        Start = 1'b0;
   logic [4:0]  Src = '0;
   logic [4:0]  Dst = '0;
   logic [5:0]  Len = '0;
`ifdef MEM_MOVER_FILL_EN
   logic        Fill = 1'b0;
   logic [31:0] FillData = '0;
`endif
   logic [31:0] MemReadData;
   logic [4:0]  MemAddy;
   logic        MemWriteEn;
   logic [31:0] MemWriteData;
   logic        Busy;
   logic        Done;

   logic [31:0] mem [32];
   logic        tb_we = 1'b0;
   logic [4:0]  tb_a = '0;
   logic [31:0] tb_d = '0;

   int n_chk = 0;
   int n_err = 0;

   mem_block_mover dut (
      .Clock        (Clock),
      .R            (R),
      .Start        (Start),
      .Src          (Src),
      .Dst          (Dst),
      .Len          (Len),
`ifdef MEM_MOVER_FILL_EN
      .Fill         (Fill),
      .FillData     (FillData),
`endif
      .MemReadData  (MemReadData),
      .MemAddy      (MemAddy),
      .MemWriteEn   (MemWriteEn),
      .MemWriteData (MemWriteData),
      .Busy         (Busy),
      .Done         (Done)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      if (MemWriteEn) mem[MemAddy] <= MemWriteData;
      else if (tb_we) mem[tb_a] <= tb_d;
   end
   assign MemReadData = mem[MemAddy];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input int a, input logic [31:0] d);
      @(negedge Clock);
      tb_we = 1'b1;
      tb_a  = 5'(a);
      tb_d  = d;
      @(posedge Clock);
      #1 tb_we = 1'b0;
   endtask

   task automatic launch(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l);
      @(negedge Clock);
      Src = s; Dst = d; Len = l; Start = 1'b1;
`ifdef MEM_MOVER_FILL_EN
      Fill = 1'b0;
`endif
      @(posedge Clock);
      #1 Start = 1'b0;
   endtask

   // Cycle k below is the k-th cycle after the edge that accepted Start (t0+k); lat=0 means no Done seen.
   task automatic run_op(input int pulse_at, output int lat, output int nwr, output int nbusy);
      lat = 0; nwr = 0; nbusy = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge Clock);
         if (MemWriteEn) nwr++;
         if (Busy) nbusy++;
         if (k == pulse_at) begin
            Start = 1'b1; Src = 5'd20; Dst = 5'd24; Len = 6'd2;
         end else begin
            Start = 1'b0;
         end
         if (Done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic count_done(input int cycles, output int nd);
      nd = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge Clock);
         if (Done) nd++;
      end
   endtask

   initial begin
      int lat, nwr, nbusy, nd;

      repeat (2) @(posedge Clock);
      @(negedge Clock);
      check("rst_addr", 32'(MemAddy), 32'd0);
      check("rst_we",   32'(MemWriteEn), 32'd0);
      check("rst_wd",   MemWriteData, 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      R = 1'b0;

      for (int i = 0; i < 32; i++) poke(i, 32'h100 + 32'(i));
      for (int i = 0; i < 4; i++) poke(2 + i, 32'hA0 + 32'(i));

      // Plain copy 2..5 -> 10..13
      launch(5'd2, 5'd10, 6'd4);
      run_op(0, lat, nwr, nbusy);
      check("cp_lat",   32'(lat), 32'd9);
      check("cp_wr",    32'(nwr), 32'd4);
      check("cp_busy",  32'(nbusy), 32'd8);
      for (int i = 0; i < 4; i++) begin
         check("cp_dst", mem[10+i], 32'hA0 + 32'(i));
         check("cp_src", mem[2+i],  32'hA0 + 32'(i));
      end
      check("cp_below", mem[9],  32'h109);
      check("cp_above", mem[14], 32'h10E);

      // Zero length, launched back-to-back in the cycle after DONE
      launch(5'd7, 5'd8, 6'd0);
      run_op(0, lat, nwr, nbusy);
      check("z_lat",  32'(lat), 32'd1);
      check("z_wr",   32'(nwr), 32'd0);
      check("z_busy", 32'(nbusy), 32'd0);
      check("z_mem8", mem[8], 32'h108);
      check("z_mem7", mem[7], 32'h107);
      // Start held during DONE must be ignored
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      count_done(5, nd);
      check("start_in_done", 32'(nd), 32'd0);

      // Wrapped forward overlap: mem[0],mem[1] are rewritten before being read as sources
      poke(30, 32'd1); poke(31, 32'd2); poke(0, 32'd3); poke(1, 32'd4);
      launch(5'd30, 5'd0, 6'd4);
      run_op(0, lat, nwr, nbusy);
      check("wr_lat", 32'(lat), 32'd9);
      check("wr_m0", mem[0], 32'd1);
      check("wr_m1", mem[1], 32'd2);
      check("wr_m2", mem[2], 32'd1);
      check("wr_m3", mem[3], 32'd2);

      // Restore source words clobbered above, then Start pulsed mid-transfer
      poke(2, 32'hA0); poke(3, 32'hA1);
      launch(5'd2, 5'd16, 6'd4);
      run_op(3, lat, nwr, nbusy);
      check("mid_lat", 32'(lat), 32'd9);
      check("mid_wr",  32'(nwr), 32'd4);
      for (int i = 0; i < 4; i++) check("mid_dst", mem[16+i], 32'hA0 + 32'(i));
      check("mid_ign", mem[24], 32'h118);
      count_done(5, nd);
      check("mid_single_done", 32'(nd), 32'd0);

      // Reset during an 8-word copy: second write lands on the reset edge, nothing after
      launch(5'd2, 5'd20, 6'd8);
      nwr = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge Clock);
         if (MemWriteEn) nwr++;
      end
      R = 1'b1;
      @(negedge Clock);
      check("r_addr", 32'(MemAddy), 32'd0);
      check("r_we",   32'(MemWriteEn), 32'd0);
      check("r_wd",   MemWriteData, 32'd0);
      check("r_busy", 32'(Busy), 32'd0);
      check("r_done", 32'(Done), 32'd0);
      R = 1'b0;
      count_done(6, nd);
      check("r_no_done", 32'(nd), 32'd0);
      check("r_wr",  32'(nwr), 32'd2);
      check("r_m20", mem[20], 32'hA0);
      check("r_m21", mem[21], 32'hA1);
      check("r_m22", mem[22], 32'h116);

`ifdef MEM_MOVER_FILL_EN
      @(negedge Clock);
      Src = 5'd0; Dst = 5'd28; Len = 6'd6; Fill = 1'b1; FillData = 32'hDEADBEEF; Start = 1'b1;
      @(posedge Clock);
      #1 Start = 1'b0;
      run_op(0, lat, nwr, nbusy);
      check("f_lat",  32'(lat), 32'd7);
      check("f_wr",   32'(nwr), 32'd6);
      check("f_busy", 32'(nbusy), 32'd6);
      for (int i = 0; i < 6; i++) check("f_mem", mem[(28+i)%32], 32'hDEADBEEF);
      check("f_m2", mem[2], 32'hA0);
      check("f_m27", mem[27], 32'h11B);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
